// File: rtl/fetch_pc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_ctrl_pkg
// Purpose  : Shared pipeline definitions for the IF-stage fetch controller:
//            the fetch FSM state encoding, the default PC width and the
//            decode-stage opcode constants used to build branch stimulus.
// Ports    : none (package)
// Options  : FETCH_STATS_EN has no effect on this file.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pc_ctrl_pkg;

  // Default program-counter width (word index).
  localparam int PC_WIDE_DEF = 7;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // Control-transfer opcodes seen by the decode stage.
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_JUMP = 6'b000010;

endpackage : fetch_pc_ctrl_pkg
`default_nettype wire

// File: rtl/fetch_pc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_ctrl_if
// Purpose  : Bundles the hazard/branch-resolution inputs and the fetch
//            outputs of fetch_pc_ctrl.
// Signals  : stall, taken, branch_pc, halt_req, resume   (to controller)
//            pc, pc_next, fetch_valid, if_id_flush, halted (from controller)
//            redirect_cnt, bubble_cnt                   (FETCH_STATS_EN only)
// Modports : master - pipeline side driving requests
//            slave  - the fetch controller
// Options  : FETCH_STATS_EN adds the two statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_pc_ctrl_if
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int PC_WIDE = PC_WIDE_DEF
);
  logic               stall;
  logic               taken;
  logic [PC_WIDE-1:0] branch_pc;
  logic               halt_req;
  logic               resume;
  logic [PC_WIDE-1:0] pc;
  logic [PC_WIDE-1:0] pc_next;
  logic               fetch_valid;
  logic               if_id_flush;
  logic               halted;
`ifdef FETCH_STATS_EN
  logic [15:0]        redirect_cnt;
  logic [15:0]        bubble_cnt;

  modport master (
    output stall, taken, branch_pc, halt_req, resume,
    input  pc, pc_next, fetch_valid, if_id_flush, halted,
    input  redirect_cnt, bubble_cnt
  );
  modport slave (
    input  stall, taken, branch_pc, halt_req, resume,
    output pc, pc_next, fetch_valid, if_id_flush, halted,
    output redirect_cnt, bubble_cnt
  );
`else
  modport master (
    output stall, taken, branch_pc, halt_req, resume,
    input  pc, pc_next, fetch_valid, if_id_flush, halted
  );
  modport slave (
    input  stall, taken, branch_pc, halt_req, resume,
    output pc, pc_next, fetch_valid, if_id_flush, halted
  );
`endif
endinterface : fetch_pc_ctrl_if
`default_nettype wire

// File: rtl/fetch_pc_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that sticks at all-ones instead of wrapping.
// Ports    : clk     - clock, rising edge
//            i_clr   - synchronous clear to zero (wins over i_en)
//            i_en    - count enable
//            o_count - current count
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             i_clr,
  input  wire logic             i_en,
  output logic      [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_en && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_ctrl
// Purpose  : IF-stage program-counter owner. Sequences boot, sequential
//            fetch, branch redirect (with IF/ID flush), hazard stall and
//            halt/resume. The PC is a word index, so sequential fetch is +1.
// Ports    : clk - clock, rising edge
//            rst - synchronous reset, active high
//            bus - fetch_pc_ctrl_if.slave (stall, taken, branch_pc,
//                  halt_req, resume in; pc, pc_next, fetch_valid,
//                  if_id_flush, halted out)
// Options  : FETCH_STATS_EN adds saturating redirect_cnt / bubble_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int                 PC_WIDE  = PC_WIDE_DEF,
  parameter logic [PC_WIDE-1:0] RESET_PC = '0
) (
  input wire logic        clk,
  input wire logic        rst,
  fetch_pc_ctrl_if.slave  bus
);

  localparam logic [PC_WIDE-1:0] C_PC_ONE = PC_WIDE'(1);
  localparam logic [PC_WIDE-1:0] C_PC_TWO = PC_WIDE'(2);

  fetch_state_e       state_q, state_d;
  logic [PC_WIDE-1:0] pc_q, pc_d;
  logic [PC_WIDE-1:0] pc_next_q, pc_next_d;
  logic               fetch_valid_q, fetch_valid_d;
  logic               halted_q, halted_d;
  logic               flush_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      pc_next_q     <= RESET_PC + C_PC_ONE;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_next_q     <= pc_next_d;
      fetch_valid_q <= fetch_valid_d;
      halted_q      <= halted_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_next_d     = pc_next_q;
    fetch_valid_d = fetch_valid_q;
    halted_d      = halted_q;
    flush_raw     = 1'b0;

    unique case (state_q)
      // One dead cycle after reset: the word at RESET_PC is fetched but not
      // yet marked valid; all requests are ignored here.
      ST_BOOT: begin
        state_d       = ST_RUN;
        fetch_valid_d = 1'b1;
      end

      ST_RUN: begin
        if (bus.taken) begin
          // Redirect beats stall: the branch is already resolved, and the
          // word entering IF/ID this cycle is the wrong path.
          pc_d          = bus.branch_pc;
          pc_next_d     = bus.branch_pc + C_PC_ONE;
          fetch_valid_d = 1'b1;
          flush_raw     = 1'b1;
        end else if (!bus.stall) begin
          pc_d          = pc_q + C_PC_ONE;
          pc_next_d     = pc_q + C_PC_TWO;
          fetch_valid_d = 1'b1;
        end
        // The step above still lands on the halting edge.
        if (bus.halt_req) begin
          state_d       = ST_HALT;
          halted_d      = 1'b1;
          fetch_valid_d = 1'b0;
        end
      end

      ST_HALT: begin
        flush_raw     = 1'b1;
        fetch_valid_d = 1'b0;
        // A simultaneous halt_req has no effect here, so resume wins.
        if (bus.resume) begin
          state_d       = ST_RUN;
          halted_d      = 1'b0;
          fetch_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.pc_next     = pc_next_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.halted      = halted_q;
  assign bus.if_id_flush = flush_raw & ~rst;

`ifdef FETCH_STATS_EN
  logic redirect_en;
  logic bubble_en;

  assign redirect_en = (state_q == ST_RUN) && bus.taken;
  // A stalled redirect cycle is one bubble, not two.
  assign bubble_en   = (flush_raw & ~rst) || ((state_q == ST_RUN) && bus.stall);

  sat_counter #(
    .WIDTH (16)
  ) u_redirect_cnt (
    .clk     (clk),
    .i_clr   (rst),
    .i_en    (redirect_en),
    .o_count (bus.redirect_cnt)
  );

  sat_counter #(
    .WIDTH (16)
  ) u_bubble_cnt (
    .clk     (clk),
    .i_clr   (rst),
    .i_en    (bubble_en),
    .o_count (bus.bubble_cnt)
  );
`endif

endmodule : fetch_pc_ctrl
`default_nettype wire

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Consumer end of the branch-resolution interface: takes the decode-stage `taken`/`branch_pc` pair and owns the program counter.
- Sequences fetch: boot, normal increment, redirect with IF/ID flush, hazard stall, halt/resume.
- Sits in the IF stage. It drives the instruction-memory address and the `pc_next` value carried in IF/ID to the decode-stage branch adder.
- PC is a word index: increment is +1.

Parameters:
- PC_WIDE, 7, width of PC, branch target and pc_next.
- RESET_PC, 0, PC value loaded on reset (PC_WIDE bits).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active high.
- stall  input  1  hazard-unit stall: hold PC and IF/ID.
- taken  input  1  decode-stage redirect request (branch taken or jump).
- branch_pc  input  PC_WIDE  redirect target, valid when taken=1.
- halt_req  input  1  freeze fetch after the current cycle.
- resume  input  1  leave HALT.
- pc  output  PC_WIDE  registered fetch address to instruction memory.
- pc_next  output  PC_WIDE  registered pc+1 of the fetched word, for IF/ID.
- fetch_valid  output  1  registered: the word fetched at `pc` is a real instruction.
- if_id_flush  output  1  combinational: discard the word being written into IF/ID this cycle.
- halted  output  1  registered: FSM is in HALT.

Behaviour:
- Reset (rst=1 at an edge, overrides everything):
  - pc=RESET_PC, pc_next=RESET_PC+1, fetch_valid=0, halted=0, state=BOOT.
  - if_id_flush=0 while rst=1.
- FSM states: BOOT, RUN, HALT.
  - BOOT: lasts exactly one cycle. pc is held, fetch_valid=0, then goes to RUN with fetch_valid=1. taken and stall are ignored in BOOT.
  - RUN, evaluated each edge in priority order:
    1. taken=1: pc<=branch_pc, pc_next<=branch_pc+1. if_id_flush=1 combinationally in the same cycle, so the wrong-path word is bubbled. This happens even if stall=1 (redirect wins; the branch itself is already resolved).
    2. stall=1: pc and pc_next are held. fetch_valid is unchanged. if_id_flush=0.
    3. Otherwise: pc<=pc+1, pc_next<=pc+2, both modulo 2^PC_WIDE.
  - RUN, halt_req=1: the step above is still applied on that edge, then state=HALT and halted=1. If taken and halt_req coincide, the redirect is applied and HALT is entered with pc=branch_pc.
  - HALT:
    - pc and pc_next are frozen; fetch_valid=0; if_id_flush=1 every cycle, so IF/ID receives bubbles.
    - taken is ignored.
    - resume=1 → RUN on the next edge with fetch_valid=1 and halted=0, continuing from the frozen pc.
    - If halt_req and resume are both 1, resume wins.
- Wrap-around: pc=2^PC_WIDE-1 increments to 0. branch_pc+1 wraps the same way. There is no overflow flag.
- Latency:
  - Redirect takes effect at the edge ending the cycle in which taken=1; the target is fetched the following cycle.
  - Redirect penalty is exactly one bubble.
- Reset during HALT or mid-redirect returns to BOOT; no pending state survives.
- pc_next always equals pc+1 (mod 2^PC_WIDE) after every edge. This is an assertion target.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined:
  - Adds outputs redirect_cnt[15:0] and bubble_cnt[15:0], both reset to 0.
  - redirect_cnt increments on each accepted redirect (RUN and taken=1).
  - bubble_cnt increments on each cycle with if_id_flush=1 or (RUN and stall=1).
  - Both counters saturate at 16'hFFFF.
- Undefined: ports and logic are absent; the remaining behaviour is identical.

Decomposition:
- Shared pipeline package holds:
  - the FSM state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2);
  - the default PC_WIDE;
  - opcode constants BEQ=6'b000100, BNE=6'b000101, JUMP=6'b000010, used by the bench for stimulus.
- One sub-module is natural: sat_counter (parameterised width, enable, synchronous clear). It is instantiated twice, only under FETCH_STATS_EN.

Test Plan:
- Reset then release → cycle 1: pc=0, fetch_valid=0. Cycle 2: pc=0, fetch_valid=1. Cycle 3: pc=1. pc_next tracks pc+1 throughout.
- Running at pc=5, taken=1 with branch_pc=40 for one cycle → if_id_flush=1 that cycle. Next cycle pc=40, pc_next=41; then pc=41.
- stall=1 for 3 cycles at pc=10 → pc stays 10 and if_id_flush=0. On stall release pc=11. Also: stall=1 and taken=1 with branch_pc=3 → pc=3 next cycle.
- PC_WIDE=7, run from pc=126 → 127, 0, 1. Also: branch_pc=127 gives pc_next=0.
- halt_req=1 at pc=20 → pc=21, halted=1, fetch_valid=0, if_id_flush=1. taken=1 is ignored during HALT. resume=1 → pc=22 the cycle after RUN resumes.
- FETCH_STATS_EN: two redirects plus three stall cycles → redirect_cnt=2, bubble_cnt=5. Preload near 16'hFFFF → holds at 16'hFFFF.
